// File: rtl/jpeg_pkg.sv
// Shared constants for the JPEG quantize + zigzag stage: widths, the luminance
// quantization table, its rounded 16-bit reciprocals, the zigzag scan and FSM states.
package jpeg_pkg;

    localparam int COEF_W  = 10;
    localparam int QOUT_W  = 8;
    localparam int RECIP_W = 13;
    localparam int PROD_W  = 23;
    localparam int NCOEF   = 64;
    localparam int IDX_W   = 6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND
    } state_e;

    typedef logic [0:NCOEF-1][6:0]         qtab_t;
    typedef logic [0:NCOEF-1][RECIP_W-1:0] rtab_t;
    typedef logic [0:NCOEF-1][IDX_W-1:0]   zztab_t;

    // Indexed by 8*row + col, row = vertical frequency.
    localparam qtab_t Q_TABLE = '{
        7'd16, 7'd11, 7'd10, 7'd16, 7'd24,  7'd40,  7'd51,  7'd61,
        7'd12, 7'd12, 7'd14, 7'd19, 7'd26,  7'd58,  7'd60,  7'd55,
        7'd14, 7'd13, 7'd16, 7'd24, 7'd40,  7'd57,  7'd69,  7'd56,
        7'd14, 7'd17, 7'd22, 7'd29, 7'd51,  7'd87,  7'd80,  7'd62,
        7'd18, 7'd22, 7'd37, 7'd56, 7'd68,  7'd109, 7'd103, 7'd77,
        7'd24, 7'd35, 7'd55, 7'd64, 7'd81,  7'd104, 7'd113, 7'd92,
        7'd49, 7'd64, 7'd78, 7'd87, 7'd103, 7'd121, 7'd120, 7'd101,
        7'd72, 7'd92, 7'd95, 7'd98, 7'd112, 7'd100, 7'd103, 7'd99
    };

    // Zigzag position k -> buffer index 8*row + col.
    localparam zztab_t ZZ_TABLE = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    // R = round(65536 / Q); no Q in the table produces an exact .5 tie.
    function automatic rtab_t build_r_table();
        rtab_t t;
        for (int i = 0; i < NCOEF; i++) begin
            t[i] = RECIP_W'((65536 + int'(Q_TABLE[i]) / 2) / int'(Q_TABLE[i]));
        end
        return t;
    endfunction

    localparam rtab_t R_TABLE = build_r_table();

endpackage

// File: rtl/quant_round.sv
// Combinational quantizer: multiplies |coef| by a 16-bit-scaled reciprocal and
// rounds half away from zero, then restores the sign.
module quant_round
    import jpeg_pkg::*;
(
    input  logic signed [COEF_W-1:0]  coef,
    input  logic        [RECIP_W-1:0] recip,
    output logic signed [QOUT_W-1:0]  q
);

    logic [COEF_W-1:0] mag;
    logic [PROD_W-1:0] prod;
    logic [QOUT_W-1:0] qmag;

    always_comb begin
        // -512 negates to the bit pattern of +512, which is correct as unsigned.
        mag  = coef[COEF_W-1] ? $unsigned(-coef) : $unsigned(coef);
        prod = PROD_W'(mag) * PROD_W'(recip) + PROD_W'(32768);
        qmag = QOUT_W'(prod >> 16);
        q    = coef[COEF_W-1] ? $signed(-qmag) : $signed(qmag);
    end

endmodule

// File: rtl/dct_quant_zigzag.sv
// Accepts a 64-coefficient DCT block, then streams it out in JPEG zigzag order,
// one quantized coefficient per beat under a valid/ready handshake.
module dct_quant_zigzag
    import jpeg_pkg::*;
#(
    parameter bit UNIT_Q = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [NCOEF*COEF_W-1:0]   coef_in,
    output logic                      in_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [QOUT_W-1:0]         out_coef,
    output logic [IDX_W-1:0]          out_index,
    output logic                      out_last
);

    state_e                          state_q, state_d;
    logic [IDX_W-1:0]                k_q, k_d;
    logic [NCOEF-1:0][COEF_W-1:0]    buf_q, buf_d;
    logic                            out_valid_q, out_valid_d;
    logic                            out_last_q, out_last_d;
    logic [QOUT_W-1:0]               out_coef_q, out_coef_d;

    logic [IDX_W-1:0]                sel_k;
    logic [IDX_W-1:0]                zz_pos;
    logic signed [COEF_W-1:0]        sel_coef;
    logic [RECIP_W-1:0]              sel_recip;
    logic signed [QOUT_W-1:0]        qr_coef;
    logic [QOUT_W-1:0]               beat_coef;
    logic                            handshake;

    // Beat being prepared: 0 when leaving LOAD, otherwise the one after k.
    always_comb begin
        sel_k     = (state_q == ST_LOAD) ? '0 : k_q + 6'd1;
        zz_pos    = ZZ_TABLE[sel_k];
        sel_coef  = $signed(buf_q[zz_pos]);
        sel_recip = R_TABLE[zz_pos];
    end

    quant_round u_quant (
        .coef  (sel_coef),
        .recip (sel_recip),
        .q     (qr_coef)
    );

    // Unit-Q build passes coefficients straight through (Q = 1 is the identity).
    assign beat_coef = UNIT_Q ? sel_coef[QOUT_W-1:0] : qr_coef;
    assign handshake = out_valid_q & out_ready;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d     = state_q;
        k_d         = k_q;
        buf_d       = buf_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_coef_d  = out_coef_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    buf_d   = coef_in;
                    k_d     = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                out_valid_d = 1'b1;
                out_last_d  = 1'b0;
                out_coef_d  = beat_coef;
                k_d         = '0;
                state_d     = ST_SEND;
            end
            ST_SEND: begin
                if (handshake) begin
                    if (k_q == 6'd63) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = ST_IDLE;
                    end else begin
                        k_d        = sel_k;
                        out_coef_d = beat_coef;
                        out_last_d = (k_q == 6'd62);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_coef_q  <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_coef_q  <= out_coef_d;
        end
    end

    // NOTE: the block buffer is deliberately left out of reset; it is always written before it is read.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_coef  = out_coef_q;
    assign out_index = k_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_dct_quant_zigzag.sv
// Directed bench for dct_quant_zigzag: a normal-Q instance and a unit-Q instance
// share all inputs and run in lockstep; use_unit picks which outputs are observed.
module tb_dct_quant_zigzag;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [639:0] coef_in;
    logic         out_ready;

    logic         m_in_ready, m_out_valid, m_out_last;
    logic [7:0]   m_out_coef;
    logic [5:0]   m_out_index;
    logic         u_in_ready, u_out_valid, u_out_last;
    logic [7:0]   u_out_coef;
    logic [5:0]   u_out_index;

    bit                 use_unit;
    logic               obs_in_ready, obs_out_valid, obs_out_last;
    logic signed [7:0]  obs_coef;
    logic [5:0]         obs_index;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q [64];

    // Zigzag order, copied independently from the JPEG standard.
    int zz_exp [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    always #5 clk = ~clk;

    dct_quant_zigzag #(.UNIT_Q(1'b0)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .coef_in   (coef_in),
        .in_ready  (m_in_ready),
        .out_valid (m_out_valid),
        .out_ready (out_ready),
        .out_coef  (m_out_coef),
        .out_index (m_out_index),
        .out_last  (m_out_last)
    );

    dct_quant_zigzag #(.UNIT_Q(1'b1)) u_dut_unit (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .coef_in   (coef_in),
        .in_ready  (u_in_ready),
        .out_valid (u_out_valid),
        .out_ready (out_ready),
        .out_coef  (u_out_coef),
        .out_index (u_out_index),
        .out_last  (u_out_last)
    );

    assign obs_in_ready  = use_unit ? u_in_ready  : m_in_ready;
    assign obs_out_valid = use_unit ? u_out_valid : m_out_valid;
    assign obs_out_last  = use_unit ? u_out_last  : m_out_last;
    assign obs_coef      = use_unit ? u_out_coef  : m_out_coef;
    assign obs_index     = use_unit ? u_out_index : m_out_index;

    task automatic check(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [639:0] put(input logic [639:0] blk, input int idx, input int val);
        logic [639:0] b;
        b = blk;
        b[idx*10 +: 10] = 10'(val);
        return b;
    endfunction

    task automatic clear_exp();
        for (int i = 0; i < 64; i++) exp_q[i] = 0;
    endtask

    // Sends one block and checks every beat against exp_q. stall selects the
    // ready pattern 1,0,0,1; abort_k >= 0 pulses rst while beat abort_k is presented.
    task automatic stream_block(input string tag, input logic [639:0] blk,
                                input bit stall, input int abort_k);
        int n;
        int cyc;
        int ph;
        coef_in  = blk;
        in_valid = 1'b1;
        cyc = 0;
        while (!obs_in_ready && cyc < 100) begin
            tick();
            cyc++;
        end
        check({tag, "_accept_wait"}, int'(obs_in_ready), 1);
        tick();
        in_valid = 1'b0;
        check({tag, "_load_valid"}, int'(obs_out_valid), 0);
        check({tag, "_load_in_ready"}, int'(obs_in_ready), 0);
        tick();
        check({tag, "_first_valid"}, int'(obs_out_valid), 1);
        n = 0;
        cyc = 0;
        ph = 0;
        while (n < 64 && cyc < 400) begin
            out_ready = stall ? ((ph % 4) == 0 || (ph % 4) == 3) : 1'b1;
            ph++;
            check({tag, "_valid"}, int'(obs_out_valid), 1);
            check({tag, "_index"}, int'(obs_index), n);
            check({tag, "_coef"}, int'(obs_coef), exp_q[n]);
            check({tag, "_last"}, int'(obs_out_last), int'(n == 63));
            if (abort_k >= 0 && n == abort_k) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                out_ready = 1'b1;
                check({tag, "_rst_valid"}, int'(obs_out_valid), 0);
                check({tag, "_rst_in_ready"}, int'(obs_in_ready), 1);
                check({tag, "_rst_index"}, int'(obs_index), 0);
                check({tag, "_rst_last"}, int'(obs_out_last), 0);
                return;
            end
            if (obs_out_valid && out_ready) n++;
            tick();
            cyc++;
        end
        out_ready = 1'b1;
        check({tag, "_beat_count"}, n, 64);
        check({tag, "_end_valid"}, int'(obs_out_valid), 0);
        check({tag, "_end_last"}, int'(obs_out_last), 0);
        check({tag, "_end_in_ready"}, int'(obs_in_ready), 1);
    endtask

    initial begin
        logic [639:0] blk;
        int cyc, n_acc, first_acc, second_acc, hits;
        bit acc, hs;
        int idx, cv;

        use_unit  = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        coef_in   = '0;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst_out_valid", int'(obs_out_valid), 0);
        check("rst_in_ready", int'(obs_in_ready), 1);
        check("rst_out_coef", int'(obs_coef), 0);
        check("rst_out_index", int'(obs_index), 0);
        check("rst_out_last", int'(obs_out_last), 0);
        rst = 1'b0;
        tick();

        // DC only: 160 / 16 = 10.
        clear_exp();
        exp_q[0] = 10;
        stream_block("dc", put('0, 0, 160), 1'b0, -1);

        // Rounding at (0,2) (Q=10, k=5) and (0,1) (Q=11, k=1).
        clear_exp(); exp_q[5] = 2;
        stream_block("rnd_p15", put('0, 2, 15), 1'b0, -1);
        clear_exp(); exp_q[5] = 1;
        stream_block("rnd_p5", put('0, 2, 5), 1'b0, -1);
        clear_exp(); exp_q[5] = -1;
        stream_block("rnd_m5", put('0, 2, -5), 1'b0, -1);
        clear_exp(); exp_q[1] = -3;
        stream_block("rnd_m37", put('0, 1, -37), 1'b0, -1);
        clear_exp(); exp_q[5] = 0;
        stream_block("rnd_p4", put('0, 2, 4), 1'b0, -1);

        // Ramp through the unit-Q build: output sequence is the zigzag table.
        blk = '0;
        for (int i = 0; i < 64; i++) blk = put(blk, i, i);
        for (int i = 0; i < 64; i++) exp_q[i] = zz_exp[i];
        use_unit = 1'b1;
        stream_block("ramp", blk, 1'b0, -1);
        stream_block("ramp_stall", blk, 1'b1, -1);
        use_unit = 1'b0;

        // Reset while beat 30 is presented, then a fresh block from k = 0.
        clear_exp(); exp_q[0] = 10;
        stream_block("abort", put('0, 0, 160), 1'b0, 30);
        clear_exp(); exp_q[1] = -3;
        stream_block("post_abort", put('0, 1, -37), 1'b0, -1);

        // Continuous in_valid with extreme coefficients: block period of 66.
        blk = put(put('0, 2, -512), 0, 511);
        coef_in   = blk;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        cyc = 0; n_acc = 0; first_acc = 0; second_acc = 0; hits = 0;
        while (n_acc < 2 && cyc < 300) begin
            acc = obs_in_ready && in_valid;
            hs  = obs_out_valid && out_ready;
            idx = int'(obs_index);
            cv  = int'(obs_coef);
            tick();
            cyc++;
            if (acc) begin
                n_acc++;
                if (n_acc == 1) first_acc = cyc;
                else second_acc = cyc;
            end
            if (hs && n_acc == 1 && idx == 0) begin
                check("cont_k0", cv, 32);
                hits++;
            end
            if (hs && n_acc == 1 && idx == 5) begin
                check("cont_k5", cv, -51);
                hits++;
            end
        end
        check("cont_accepts", n_acc, 2);
        check("cont_hits", hits, 2);
        check("cont_period", second_acc - first_acc, 66);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("final_in_ready", int'(obs_in_ready), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
